// File: rtl/reg_file_pkg.sv
// reg_file_pkg: register-file constants and the readout FSM state type.
package reg_file_pkg;
    localparam int ACC_IDX   = 14;
    localparam int ALIAS_IDX = 15;
    localparam int NUM_PHYS  = 15;
    typedef enum logic [2:0] {IDLE, HALT, READ, SEND, DONE} reg_dump_state_t;
endpackage

// File: rtl/reg_dump.sv
// reg_dump: halts the core and streams physical registers out over valid/ready.
module reg_dump
    import reg_file_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int REG_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [REG_ADDR_WIDTH-1:0] start_addr,
    input  logic [REG_ADDR_WIDTH-1:0] count,
    input  logic                      abort,
    output logic                      halt_req,
    input  logic                      halt_ack,
    output logic [REG_ADDR_WIDTH-1:0] rf_rd_addr,
    input  logic [REG_WIDTH-1:0]      rf_rd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REG_WIDTH-1:0]      out_data,
    output logic [REG_ADDR_WIDTH-1:0] out_index,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);
    localparam int AW = REG_ADDR_WIDTH;

    reg_dump_state_t state, next;
    logic [AW-1:0] addr, remaining, last_addr, start_c, count_c;
    logic abort_pend, hs;

    assign start_c    = (start_addr >= AW'(NUM_PHYS)) ? '0 : start_addr;
    assign count_c    = ({1'b0, count} > (AW+1)'(NUM_PHYS)) ? AW'(NUM_PHYS) : count;
    assign hs         = out_valid && out_ready;
    assign rf_rd_addr = (state == READ) ? addr : last_addr;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? ((count_c == '0) ? DONE : HALT) : IDLE;
            HALT:    next = abort ? DONE : (halt_ack ? READ : HALT);
            READ:    next = abort ? DONE : SEND;
            SEND:    next = !hs ? SEND : ((remaining == AW'(1) || abort || abort_pend) ? DONE : READ);
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            remaining  <= '0;
            last_addr  <= '0;
            abort_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_index  <= '0;
            out_last   <= 1'b0;
            halt_req   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            halt_req <= next inside {HALT, READ, SEND};
            busy     <= next != IDLE;
            done     <= next == DONE;
            if (state == IDLE && start) begin
                addr       <= start_c;
                remaining  <= count_c;
                abort_pend <= 1'b0;
            end
            if (state == READ) begin
                last_addr <= addr;
                out_data  <= rf_rd_data;
                out_index <= addr;
                out_last  <= remaining == AW'(1);
                out_valid <= !abort;
            end
            if (state == SEND) begin
                if (abort) abort_pend <= 1'b1;
                if (hs) begin
                    out_valid <= 1'b0;
                    remaining <= remaining - 1'b1;
                    addr      <= (addr == AW'(ACC_IDX)) ? '0 : addr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: randomized dumps checked against a queue model of the expected beat stream.
module tb_reg_dump;
    logic       clk = 0, rst_n = 0, start = 0, abort = 0, halt_ack = 0, out_ready = 0;
    logic [3:0] start_addr = 0, count = 0, rf_rd_addr, out_index;
    logic [7:0] rf_rd_data, out_data;
    logic       halt_req, out_valid, out_last, busy, done;

    reg_dump dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .count(count),
        .abort(abort), .halt_req(halt_req), .halt_ack(halt_ack), .rf_rd_addr(rf_rd_addr),
        .rf_rd_data(rf_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] regs [15];
    assign rf_rd_data = (rf_rd_addr < 4'd15) ? regs[rf_rd_addr] : 8'hEE;

    typedef struct { int idx; int data; int last; } beat_t;
    beat_t exp_q[$];
    beat_t mb;
    int n_tests = 0, n_fail = 0, cyc = 0, hs_cyc = -1, beats = 0, ready_mode = 0;
    bit halt_seen;
    logic pv_stall = 0, pv_l;
    logic [7:0] pv_d;
    logic [3:0] pv_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int build(input int sa, input int cnt);
        int s, n;
        s = (sa >= 15) ? 0 : sa;
        n = (cnt > 15) ? 15 : cnt;
        for (int i = 0; i < n; i++)
            exp_q.push_back('{(s + i) % 15, int'(regs[(s + i) % 15]), int'(i == n - 1)});
        return n;
    endfunction

    always @(posedge clk) cyc++;

    initial forever begin
        @(posedge clk); #1;
        out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom % 2) : 1'b0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (halt_req) halt_seen = 1;
            if (busy) check("rd_addr_not_alias", rf_rd_addr == 4'd15, 0);
            if (pv_stall && out_valid) begin
                check("stall_data", out_data, pv_d);
                check("stall_index", out_index, pv_i);
                check("stall_last", out_last, pv_l);
            end
            if (out_valid && out_ready) begin
                beats++;
                hs_cyc = cyc;
                if (exp_q.size() == 0) check("extra_beat", 1, 0);
                else begin
                    mb = exp_q.pop_front();
                    check("beat_index", out_index, mb.idx);
                    check("beat_data", out_data, mb.data);
                    check("beat_last", out_last, mb.last);
                end
            end
            pv_stall = out_valid && !out_ready;
            pv_d = out_data; pv_i = out_index; pv_l = out_last;
        end else pv_stall = 0;
    end

    task automatic run_dump(input int sa, input int cnt, input int ack_dly, input int abort_at);
        int n, k;
        n = build(sa, cnt);
        halt_seen = 0;
        beats = 0;
        @(negedge clk); start_addr = 4'(sa); count = 4'(cnt); start = 1;
        @(negedge clk); start = 0;
        check("halt_req_after_start", halt_req, int'(n > 0));
        check("busy_after_start", busy, 1);
        if (n == 0) begin
            check("done_zero_count", done, 1);
            check("zero_no_halt", halt_seen, 0);
        end else begin
            repeat (ack_dly - 1) @(negedge clk);
            halt_ack = 1;
            if (abort_at >= 0) begin
                for (k = 0; k < 2000 && !(beats == abort_at && out_valid); k++) @(negedge clk);
                check("abort_reached", beats == abort_at && out_valid, 1);
                check("abort_beat_not_last", out_last, 0);
                while (exp_q.size() > 1) void'(exp_q.pop_back());
                abort = 1;
                @(negedge clk); abort = 0;
            end
            for (k = 0; k < 3000 && !done; k++) @(negedge clk);
            check("done_seen", done, 1);
            check("done_latency", cyc - hs_cyc, 1);
            check("halt_req_at_done", halt_req, 0);
        end
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_idle", busy, 0);
        check("halt_req_idle", halt_req, 0);
        halt_ack = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_halt_req", halt_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_addr", rf_rd_addr, 0);
        rst_n = 1;
        for (int i = 0; i < 15; i++) regs[i] = 8'(8'h10 + i);
        ready_mode = 0;
        run_dump(0, 15, 3, -1);
        run_dump(13, 4, 2, -1);
        for (int i = 0; i < 15; i++) regs[i] = 8'($urandom);
        ready_mode = 1;
        run_dump(5, 15, 1, -1);
        for (int t = 0; t < 6; t++)
            run_dump($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(1, 4), -1);
        run_dump(3, 0, 1, -1);
        run_dump(15, 15, 2, -1);
        run_dump(0, 10, 2, 2);
        ready_mode = 0;
        run_dump(6, 8, 2, 2);
        ready_mode = 2;
        void'(build(4, 6));
        @(negedge clk); start_addr = 4; count = 6; start = 1;
        @(negedge clk); start = 0; halt_ack = 1;
        for (int k = 0; k < 200 && !out_valid; k++) @(negedge clk);
        check("pre_reset_valid", out_valid, 1);
        rst_n = 0;
        #1;
        check("reset_mid_out_valid", out_valid, 0);
        check("reset_mid_halt_req", halt_req, 0);
        check("reset_mid_busy", busy, 0);
        exp_q.delete();
        @(negedge clk); rst_n = 1; halt_ack = 0; ready_mode = 1;
        run_dump(7, 5, 2, -1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
